// File: rtl/inst_seq.sv
// Instruction sequencer: buffers a host-loaded program and replays it n_iter
// times into the PE control decoder, then waits out write-back and pulses done.
module inst_seq #(
  parameter int INST_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int ITER_W     = 8,
  parameter int DRAIN_CYC  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_v,
  input  logic [INST_WIDTH-1:0] ld_inst,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ITER_W-1:0]     n_iter,
  input  logic                  hold,
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  ld_full,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W:0]         count_q, count_d;
  logic [ADDR_W:0]         len_q, len_d;
  logic [ITER_W-1:0]       iters_q, iters_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    inst_v_q, inst_v_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic                    done_q, done_d;

  logic [INST_WIDTH-1:0]   mem [DEPTH];
  logic                    wr_en;
  logic                    last_pc;
  logic                    last_iter;

  assign ld_full   = (count_q == (ADDR_W+1)'(DEPTH));
  assign busy      = (state_q != IDLE);
  assign inst_v    = inst_v_q;
  assign inst      = inst_q;
  assign done      = done_q;
  assign last_pc   = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
  assign last_iter = (iter_q == (iters_q - ITER_W'(1)));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    iters_d  = iters_q;
    iter_d   = iter_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    inst_v_d = 1'b0;
    inst_d   = '0;
    done_d   = 1'b0;
    wr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        // An accepted start outranks clear and load; a start on an empty buffer is a no-op.
        if (start && (count_q != '0)) begin
          len_d   = count_q;
          iters_d = (n_iter == '0) ? ITER_W'(1) : n_iter;
          pc_d    = '0;
          iter_d  = '0;
          state_d = RUN;
        end else if (clear) begin
          count_d = '0;
        end else if (ld_v && !ld_full) begin
          wr_en   = 1'b1;
          count_d = count_q + (ADDR_W+1)'(1);
        end
      end
      RUN: begin
        if (!hold) begin
          inst_v_d = 1'b1;
          inst_d   = mem[pc_q];
          if (last_pc) begin
            pc_d = '0;
            if (last_iter) begin
              cnt_d   = '0;
              state_d = DRAIN;
            end else begin
              iter_d = iter_q + ITER_W'(1);
            end
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      len_q    <= '0;
      iters_q  <= '0;
      iter_q   <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      inst_v_q <= 1'b0;
      inst_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      iters_q  <= iters_d;
      iter_q   <= iter_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      inst_v_q <= inst_v_d;
      inst_q   <= inst_d;
      done_q   <= done_d;
    end
  end

  // Program storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[ADDR_W-1:0]] <= ld_inst;
    end
  end

endmodule

// File: tb/tb_inst_seq.sv
// Directed testbench for inst_seq: load/replay, iteration, overflow, hold,
// empty-start, n_iter=0 and asynchronous reset abort.
module tb_inst_seq;

  localparam logic [63:0] I_A = 64'h8000_0000_0100_0A0A;
  localparam logic [63:0] I_B = 64'h0000_0000_0200_0B0B;
  localparam logic [63:0] I_C = 64'h8000_0000_0300_0C0C;
  localparam logic [63:0] I_D = 64'h0000_0000_0400_0D0D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_v;
  logic [63:0] ld_inst;
  logic        clear;
  logic        start;
  logic [7:0]  n_iter;
  logic        hold;
  logic        inst_v;
  logic [63:0] inst;
  logic        ld_full;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  logic        obs_v    [0:63];
  logic [63:0] obs_inst [0:63];
  logic        obs_done [0:63];
  logic        obs_busy [0:63];

  inst_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_v    (ld_v),
    .ld_inst (ld_inst),
    .clear   (clear),
    .start   (start),
    .n_iter  (n_iter),
    .hold    (hold),
    .inst_v  (inst_v),
    .inst    (inst),
    .ld_full (ld_full),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic load_inst(input logic [63:0] v);
    @(negedge clk);
    ld_v    = 1'b1;
    ld_inst = v;
    @(negedge clk);
    ld_v    = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Sample 0 is taken just after the start edge; sample i+1 reflects the edge
  // that followed sample i, with hold driven from hold_mask[i] for that edge.
  task automatic run_program(input logic [7:0] n, input logic [63:0] hold_mask,
                             input int ncyc, input logic ld_with_start);
    @(negedge clk);
    n_iter  = n;
    start   = 1'b1;
    ld_v    = ld_with_start;
    ld_inst = I_D;
    @(negedge clk);
    start = 1'b0;
    ld_v  = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      obs_v[i]    = inst_v;
      obs_inst[i] = inst;
      obs_done[i] = done;
      obs_busy[i] = busy;
      if (i < ncyc - 1) begin
        hold = hold_mask[i];
        @(negedge clk);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({inst_v, inst, done, busy, ld_full} !== 68'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got v=%0b inst=%h done=%0b busy=%0b full=%0b, want all 0",
               inst_v, inst, done, busy, ld_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({inst_v, done, busy, ld_full} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_idle: got v=%0b done=%0b busy=%0b full=%0b, want 0",
               inst_v, done, busy, ld_full);
    end
  endtask

  task automatic test_single_pass();
    logic [63:0] seq [3];
    logic [63:0] e;
    seq = '{I_A, I_B, I_C};
    do_clear();
    load_inst(I_A);
    load_inst(I_B);
    load_inst(I_C);
    run_program(8'd1, 64'h0, 12, 1'b0);
    for (int i = 1; i < 12; i++) begin
      e = (i <= 3) ? seq[i-1] : 64'h0;
      tests_run++;
      if ({obs_v[i], obs_inst[i]} !== {(e != 64'h0), e}) begin
        tests_failed++;
        $display("[TB] FAIL single_pass_issue[%0d]: got v=%0b inst=%h, want v=%0b inst=%h",
                 i, obs_v[i], obs_inst[i], (e != 64'h0), e);
      end
      tests_run++;
      if (obs_done[i] !== (i == 9)) begin
        tests_failed++;
        $display("[TB] FAIL single_pass_done[%0d]: got %0b, want %0b", i, obs_done[i], (i == 9));
      end
    end
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (obs_busy[i] !== (i < 9)) begin
        tests_failed++;
        $display("[TB] FAIL single_pass_busy[%0d]: got %0b, want %0b", i, obs_busy[i], (i < 9));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    do_clear();
    load_inst(I_A);
    load_inst(I_B);
    run_program(8'd3, 64'h0, 15, 1'b0);
    for (int i = 1; i < 15; i++) begin
      e = (i > 6) ? 64'h0 : ((i % 2 == 1) ? I_A : I_B);
      tests_run++;
      if ({obs_v[i], obs_inst[i]} !== {(e != 64'h0), e}) begin
        tests_failed++;
        $display("[TB] FAIL b2b_issue[%0d]: got v=%0b inst=%h, want v=%0b inst=%h",
                 i, obs_v[i], obs_inst[i], (e != 64'h0), e);
      end
      tests_run++;
      if (obs_done[i] !== (i == 12)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_done[%0d]: got %0b, want %0b", i, obs_done[i], (i == 12));
      end
    end
    // Buffer is retained after done, so a bare restart replays it.
    run_program(8'd1, 64'h0, 10, 1'b0);
    for (int i = 1; i < 10; i++) begin
      e = (i == 1) ? I_A : ((i == 2) ? I_B : 64'h0);
      tests_run++;
      if ({obs_v[i], obs_inst[i], obs_done[i]} !== {(e != 64'h0), e, (i == 8)}) begin
        tests_failed++;
        $display("[TB] FAIL restart[%0d]: got v=%0b inst=%h done=%0b, want v=%0b inst=%h done=%0b",
                 i, obs_v[i], obs_inst[i], obs_done[i], (e != 64'h0), e, (i == 8));
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] e;
    do_clear();
    for (int k = 0; k < 18; k++) begin
      load_inst({32'hC0DE_0000, 32'(k + 1)});
      if (k == 14 || k == 15 || k == 17) begin
        tests_run++;
        if (ld_full !== (k >= 15)) begin
          tests_failed++;
          $display("[TB] FAIL ld_full_after_%0d: got %0b, want %0b", k + 1, ld_full, (k >= 15));
        end
      end
    end
    run_program(8'd1, 64'h0, 24, 1'b0);
    for (int i = 1; i < 24; i++) begin
      e = (i <= 16) ? {32'hC0DE_0000, 32'(i)} : 64'h0;
      tests_run++;
      if ({obs_v[i], obs_inst[i], obs_done[i]} !== {(e != 64'h0), e, (i == 22)}) begin
        tests_failed++;
        $display("[TB] FAIL overflow_replay[%0d]: got v=%0b inst=%h done=%0b, want v=%0b inst=%h done=%0b",
                 i, obs_v[i], obs_inst[i], obs_done[i], (e != 64'h0), e, (i == 22));
      end
    end
  endtask

  task automatic test_hold();
    logic [63:0] seq [6];
    logic [63:0] e;
    seq = '{I_A, 64'h0, 64'h0, I_B, I_C, 64'h0};
    do_clear();
    load_inst(I_A);
    load_inst(I_B);
    load_inst(I_C);
    run_program(8'd1, 64'h6, 14, 1'b0);
    for (int i = 1; i < 14; i++) begin
      e = (i <= 6) ? seq[i-1] : 64'h0;
      tests_run++;
      if ({obs_v[i], obs_inst[i], obs_done[i]} !== {(e != 64'h0), e, (i == 11)}) begin
        tests_failed++;
        $display("[TB] FAIL hold[%0d]: got v=%0b inst=%h done=%0b, want v=%0b inst=%h done=%0b",
                 i, obs_v[i], obs_inst[i], obs_done[i], (e != 64'h0), e, (i == 11));
      end
    end
  endtask

  task automatic test_empty_and_zero_iter();
    logic [63:0] seq [3];
    logic [63:0] e;
    seq = '{I_A, I_B, I_C};
    do_clear();
    // clear and ld_v together: clear must win, leaving the buffer empty
    @(negedge clk);
    clear   = 1'b1;
    ld_v    = 1'b1;
    ld_inst = I_D;
    @(negedge clk);
    clear = 1'b0;
    ld_v  = 1'b0;
    run_program(8'd1, 64'h0, 6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({obs_busy[i], obs_v[i], obs_done[i]} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL empty_start[%0d]: got busy=%0b v=%0b done=%0b, want 0",
                 i, obs_busy[i], obs_v[i], obs_done[i]);
      end
    end
    load_inst(I_A);
    load_inst(I_B);
    load_inst(I_C);
    // n_iter=0 means one pass; the ld_v in the start cycle must be dropped
    for (int pass = 0; pass < 2; pass++) begin
      run_program(8'd0, 64'h0, 12, (pass == 0));
      for (int i = 1; i < 12; i++) begin
        e = (i <= 3) ? seq[i-1] : 64'h0;
        tests_run++;
        if ({obs_v[i], obs_inst[i], obs_done[i]} !== {(e != 64'h0), e, (i == 9)}) begin
          tests_failed++;
          $display("[TB] FAIL zero_iter_p%0d[%0d]: got v=%0b inst=%h done=%0b, want v=%0b inst=%h done=%0b",
                   pass, i, obs_v[i], obs_inst[i], obs_done[i], (e != 64'h0), e, (i == 9));
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] e;
    do_clear();
    load_inst(I_A);
    load_inst(I_B);
    load_inst(I_C);
    @(negedge clk);
    n_iter = 8'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({inst_v, inst, busy} !== {1'b1, I_A, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL abort_precond: got v=%0b inst=%h busy=%0b, want v=1 inst=%h busy=1",
               inst_v, inst, busy, I_A);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({inst_v, inst, busy, done, ld_full} !== 68'h0) begin
      tests_failed++;
      $display("[TB] FAIL abort_async: got v=%0b inst=%h busy=%0b done=%0b full=%0b, want all 0",
               inst_v, inst, busy, done, ld_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_program(8'd1, 64'h0, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({obs_busy[i], obs_v[i], obs_done[i]} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL start_after_abort[%0d]: got busy=%0b v=%0b done=%0b, want 0",
                 i, obs_busy[i], obs_v[i], obs_done[i]);
      end
    end
    load_inst(I_C);
    load_inst(I_A);
    run_program(8'd1, 64'h0, 10, 1'b0);
    for (int i = 1; i < 10; i++) begin
      e = (i == 1) ? I_C : ((i == 2) ? I_A : 64'h0);
      tests_run++;
      if ({obs_v[i], obs_inst[i], obs_done[i]} !== {(e != 64'h0), e, (i == 8)}) begin
        tests_failed++;
        $display("[TB] FAIL reload_after_abort[%0d]: got v=%0b inst=%h done=%0b, want v=%0b inst=%h done=%0b",
                 i, obs_v[i], obs_inst[i], obs_done[i], (e != 64'h0), e, (i == 8));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ld_v    = 1'b0;
    ld_inst = '0;
    clear   = 1'b0;
    start   = 1'b0;
    n_iter  = '0;
    hold    = 1'b0;
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_overflow();
    test_hold();
    test_empty_and_zero_iter();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
